// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine
// ----------------
// Iterative forward AES SubBytes engine for the encrypt round loop, placed
// between AddRoundKey and ShiftRows. It takes one 128-bit state over a
// valid/ready handshake. Each clock it passes BYTES_PER_CYCLE bytes through
// the FIPS-197 forward S-box. When every byte is done, it presents the
// substituted state on a valid/ready output port.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   in_data carries a state
//   in_ready   engine is idle and can accept a state
//   in_data    input state, byte 0 = [127:120], byte 15 = [7:0]
//   out_valid  out_data carries the substituted state
//   out_ready  downstream accepts out_data
//   out_data   substituted state, same byte order as in_data
//   out_parity (only with SUB_BYTES_PARITY_EN) per-byte XOR of out_data,
//              output byte i -> bit 15-i
//
// Parameters:
//   BYTES_PER_CYCLE  S-box lookups per clock. Legal values are 1, 2, 4, 8
//                    and 16.
//
// Optional feature macro: SUB_BYTES_PARITY_EN

module sub_bytes_engine #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
`ifdef SUB_BYTES_PARITY_EN
    ,
    output logic [15:0]  out_parity
`endif
);

    localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    // Reject slice widths that do not divide the 16-byte state into equal
    // power-of-two steps.
    generate
        if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
            BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
            $error("sub_bytes_engine: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Forward S-box. Entry 0x00 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [STEP_W-1:0]   step;
    logic [127:0]        work;
    logic [127:0]        next_work;
    logic [7:0]          sub_in  [BYTES_PER_CYCLE];
    logic [7:0]          sub_out [BYTES_PER_CYCLE];

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [15:0] byte_parity(input logic [127:0] d);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            p[15-i] = ^d[127 - 8*i -: 8];
        end
        return p;
    endfunction

    // Pick out the slice addressed by the step counter. Each lane k handles
    // byte step*BPC+k, so the lowest byte index of the slice goes to lane 0.
    always_comb begin
        for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
            sub_in[k]  = work[127 - 8*(int'(step)*BYTES_PER_CYCLE + k) -: 8];
            sub_out[k] = sbox(sub_in[k]);
        end
    end

    // Merge the substituted slice back into the working state. All other
    // bytes pass through unchanged.
    always_comb begin
        next_work = work;
        for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
            next_work[127 - 8*(int'(step)*BYTES_PER_CYCLE + k) -: 8] = sub_out[k];
        end
    end

    // Control FSM with registered handshake outputs.
    // in_ready is high only in IDLE, so a new state is taken one clock after
    // the output handshake. out_data is loaded once, on the final BUSY step,
    // which keeps it stable under backpressure. It also holds its last value
    // after the handshake, so the port never shows a half-done state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= '0;
            work       <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
`ifdef SUB_BYTES_PARITY_EN
            out_parity <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= in_data;
                        step     <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    work <= next_work;
                    if (step == LAST_STEP) begin
                        step       <= '0;
                        out_valid  <= 1'b1;
                        out_data   <= next_work;
`ifdef SUB_BYTES_PARITY_EN
                        out_parity <= byte_parity(next_work);
`endif
                        state      <= DONE;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
